mcycle_seq: RTL
===============

// Module: mcycle_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the RV32M ops, sitting in EX beside the ALU.
//  Drives the Busy input of the hazard unit, which stalls IF/ID while an op runs.
//  Returns one WIDTH-bit result with a fixed, deterministic latency.
//  Start is ignored in the cycle after completion, so the op held in EX is not re-issued.
// PARAMETERS
//  WIDTH  32  operand/result width (even, >=4); iterations per normal op = WIDTH
// PORTS
//  CLK        in   1      clock, rising edge
//  RESET      in   1      asynchronous, active-high reset
//  Start      in   1      EX holds an M-extension op; level, held while Busy=1
//  MCycleOp   in   3      funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  Operand1   in   WIDTH  rs1 value (forwarded), sampled in the Start cycle only
//  Operand2   in   WIDTH  rs2 value (forwarded), sampled in the Start cycle only
//  Result     out  WIDTH  registered result, valid while state==DONE, held until next op latches
//  Busy       out  1      combinational: (IDLE & Start & !fast) | COMPUTING | (IDLE & Start & fast)
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0, Result=0, all work regs=0; Busy=0 right after reset.
//  Reset mid-op aborts with no result; the next Start begins afresh.
//  States: IDLE, COMPUTING, DONE.
//  IDLE:
//   - Start=0: Busy=0, nothing changes.
//   - Start=1: Busy=1 in this same cycle. At the edge, latch op and |Operand1|,|Operand2| per signedness:
//     MULH/DIV/REM: both signed; MULHSU: op1 signed only; MULHU/DIVU/REMU/MUL: unsigned.
//     Also latch neg flags, set count=0, go COMPUTING.
//  Fast path, decided in the IDLE Start cycle, skips COMPUTING and goes straight to DONE:
//   - divide by zero: DIV/DIVU -> all ones; REM/REMU -> Operand1.
//   - signed overflow: DIV of -2^(W-1) by -1 -> -2^(W-1); REM -> 0.
//   - Busy is high for exactly 1 cycle.
//  COMPUTING: Busy=1, one iteration per cycle, count++.
//   - mul: shift-add on 2*WIDTH product reg, multiplier LSB gates the add of the multiplicand.
//   - div: restoring. remainder={rem,quot_msb}; subtract divisor; if no borrow set quot bit, else keep.
//   - At the edge where count==WIDTH-1: apply sign fix-up.
//     Product is negated if neg1^neg2; quotient likewise; remainder takes the dividend's sign.
//     Select low/high half or quotient/remainder, latch Result, go DONE.
//  DONE: Busy=0 and Result valid for exactly this cycle; Start ignored; always -> IDLE next edge.
//  Latency: normal op Busy=1 for WIDTH+1 consecutive cycles (Start cycle + WIDTH), Result
//   valid in cycle WIDTH+1 counted from the Start cycle as 0.
//  Back-to-back ops: the earliest new Start is sampled in the IDLE cycle after DONE.
//  Width rules: all negation is two's complement in WIDTH bits. -2^(W-1) magnitude is held
//   unsigned in WIDTH bits, with no overflow.
//  Operand changes after the Start cycle have no effect.
//  MCycleOp is never re-read after latch.
// STRUCTURE
//  Shared header mcycle_defs.vh:
//   - op encodings (MC_MUL..MC_REMU)
//   - state localparams S_IDLE/S_COMPUTING/S_DONE
//   - helper widths (CNT_W = $clog2(WIDTH))
//  One natural sub-module: mcycle_div_step, the combinational one-bit restoring step
//   (rem_in, quot_in, divisor -> rem_out, quot_out). The mul step stays inline.
//  FSM, counter, sign fix-up and result mux live in mcycle_seq.
// TESTING (WIDTH=32)
//  1 MUL 7*-3, Start held -> Busy high 33 cycles. DONE cycle: Result=0xFFFFFFEB, Busy=0.
//    Next cycle IDLE; Start still high -> new op begins.
//  2 MULH/MULHU/MULHSU of 0x80000000 and 0xFFFFFFFF -> 0x00000000 / 0x7FFFFFFF / 0x80000000.
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIVU 5/0 -> Busy high 1 cycle, Result=0xFFFFFFFF.
//    REM 0x80000000/0xFFFFFFFF -> Busy 1 cycle, Result=0.
//  5 RESET pulsed in COMPUTING (count=10) -> Busy=0 at once, Result=0, state IDLE.
//    A following MUL 3*4 -> 12 with full latency.
//  6 Operands changed every cycle after Start -> Result matches the Start-cycle values.

Source files
------------

// File: rtl/mcycle_seq_pkg.sv
// mcycle_seq_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   mcOpE      - funct3 encodings of the M-extension ops
//   stateE     - sequencer FSM states
//   op1Signed  - true when rs1 is interpreted as signed for the op
//   op2Signed  - true when rs2 is interpreted as signed for the op
package mcycle_seq_pkg;

  typedef enum logic [2:0] {
    MC_MUL    = 3'b000,
    MC_MULH   = 3'b001,
    MC_MULHSU = 3'b010,
    MC_MULHU  = 3'b011,
    MC_DIV    = 3'b100,
    MC_DIVU   = 3'b101,
    MC_REM    = 3'b110,
    MC_REMU   = 3'b111
  } mcOpE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTING,
    S_DONE
  } stateE;

  function automatic logic op1Signed(input mcOpE op);
    return (op == MC_MULH) || (op == MC_MULHSU) || (op == MC_DIV) || (op == MC_REM);
  endfunction

  function automatic logic op2Signed(input mcOpE op);
    return (op == MC_MULH) || (op == MC_DIV) || (op == MC_REM);
  endfunction

endpackage

// File: rtl/mcycle_div_step.sv
// mcycle_div_step: one combinational iteration of restoring unsigned division.
//   remIn    in   WIDTH  partial remainder (always < divisor)
//   quotIn   in   WIDTH  dividend bits still to shift in (MSB first) / quotient so far
//   divisor  in   WIDTH  divisor magnitude
//   remOut   out  WIDTH  updated partial remainder
//   quotOut  out  WIDTH  quotIn shifted left with the new quotient bit in the LSB
module mcycle_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quotIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quotOut
);

  logic [WIDTH:0] remShift;
  logic           noBorrow;

  // Shifted remainder is < 2*divisor, so one trial subtraction suffices.
  assign remShift = {remIn, quotIn[WIDTH-1]};
  assign noBorrow = (remShift >= {1'b0, divisor});
  assign remOut   = noBorrow ? WIDTH'(remShift - {1'b0, divisor}) : remShift[WIDTH-1:0];
  assign quotOut  = {quotIn[WIDTH-2:0], noBorrow};

endmodule

// File: rtl/mcycle_seq.sv
// mcycle_seq: iterative RV32M multiply/divide sequencer in EX.
//   CLK       in   1      clock, rising edge
//   RESET     in   1      asynchronous active-high reset
//   Start     in   1      EX holds an M-extension op (level, held while Busy)
//   MCycleOp  in   3      funct3 of the op
//   Operand1  in   WIDTH  rs1 value, sampled in the Start cycle only
//   Operand2  in   WIDTH  rs2 value, sampled in the Start cycle only
//   Result    out  WIDTH  registered result, valid in DONE, held until next op latches
//   Busy      out  1      stall request to the hazard unit
// Normal ops take WIDTH iterations; divide-by-zero and signed overflow finish
// directly from the Start cycle.
module mcycle_seq
  import mcycle_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [2:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  stateE              state, stateNext;
  mcOpE               opReg;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   mcand;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] work;           // product, or {remainder, quotient}
  logic [CNT_W-1:0]   count;

  // Start-cycle decode
  mcOpE             opIn;
  logic             inNeg1, inNeg2;
  logic [WIDTH-1:0] inMag1, inMag2;
  logic             divByZero, overflow, fast;
  logic [WIDTH-1:0] fastResult;

  // Iteration datapath
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH-1:0]   remOut, quotOut;
  logic [2*WIDTH-1:0] workNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;
  logic [WIDTH-1:0]   finalResult;

  assign opIn   = mcOpE'(MCycleOp);
  assign inNeg1 = op1Signed(opIn) & Operand1[WIDTH-1];
  assign inNeg2 = op2Signed(opIn) & Operand2[WIDTH-1];
  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  assign inMag1 = inNeg1 ? -Operand1 : Operand1;
  assign inMag2 = inNeg2 ? -Operand2 : Operand2;

  assign divByZero = MCycleOp[2] && (Operand2 == '0);
  assign overflow  = ((opIn == MC_DIV) || (opIn == MC_REM)) &&
                     (Operand1 == MIN_NEG) && (Operand2 == '1);
  assign fast      = divByZero || overflow;

  always_comb begin
    fastResult = '0;
    if (divByZero) begin
      fastResult = ((opIn == MC_DIV) || (opIn == MC_DIVU)) ? '1 : Operand1;
    end else if (overflow) begin
      fastResult = (opIn == MC_DIV) ? MIN_NEG : '0;
    end
  end

  // Shift-add multiply: multiplier sits in the low half and drains out the
  // bottom while the partial product accumulates into the top.
  assign mulSum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  assign mulNext = work[0] ? {mulSum, work[WIDTH-1:1]} : {1'b0, work[2*WIDTH-1:1]};

  mcycle_div_step #(.WIDTH(WIDTH)) uDivStep (
    .remIn   (work[2*WIDTH-1:WIDTH]),
    .quotIn  (work[WIDTH-1:0]),
    .divisor (mcand),
    .remOut  (remOut),
    .quotOut (quotOut)
  );

  assign workNext = opReg[2] ? {remOut, quotOut} : mulNext;

  // Sign fix-up applied to the final iteration's output so the result
  // latches on the same edge as the last step.
  assign prodFix = (neg1 ^ neg2) ? -workNext : workNext;
  assign quotFix = (neg1 ^ neg2) ? -quotOut : quotOut;
  assign remFix  = neg1 ? -remOut : remOut;

  always_comb begin
    finalResult = '0;
    unique case (opReg)
      MC_MUL:                        finalResult = prodFix[WIDTH-1:0];
      MC_MULH, MC_MULHSU, MC_MULHU:  finalResult = prodFix[2*WIDTH-1:WIDTH];
      MC_DIV, MC_DIVU:               finalResult = quotFix;
      MC_REM, MC_REMU:               finalResult = remFix;
      default:                       finalResult = '0;
    endcase
  end

  always_comb begin
    stateNext = state;
    Busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          Busy      = 1'b1;
          stateNext = fast ? S_DONE : S_COMPUTING;
        end
      end
      S_COMPUTING: begin
        Busy = 1'b1;
        if (count == LAST_CNT) stateNext = S_DONE;
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      opReg  <= MC_MUL;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      mcand  <= '0;
      work   <= '0;
      count  <= '0;
      Result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            opReg <= opIn;
            neg1  <= inNeg1;
            neg2  <= inNeg2;
            mcand <= inMag2;
            // Same load for both: multiplier or dividend in the low half.
            work  <= {{WIDTH{1'b0}}, inMag1};
            count <= '0;
            if (fast) Result <= fastResult;
          end
        end
        S_COMPUTING: begin
          work  <= workNext;
          count <= count + 1'b1;
          if (count == LAST_CNT) Result <= finalResult;
        end
        default: ;
      endcase
    end
  end

endmodule
